// File: rtl/sha_pkg.sv
// sha_pkg: shared widths, SHA-256 padding constants and scheduler state encodings.
package sha_pkg;
    localparam int HDR_W  = 640;
    localparam int MSG_W  = 1024;
    localparam int HASH_W = 256;
    localparam logic [63:0] MSG_LEN_FIELD = 64'd640;
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_REPORT, S_DONE
    } state_t;
endpackage

// File: rtl/sha_msg_pad.sv
// sha_msg_pad: 76 header bytes + nonce -> padded two-block SHA-256 message for an 80-byte input.
module sha_msg_pad
    import sha_pkg::*;
(
    input  logic [HDR_W-1:32] hdr_i,
    input  logic [31:0]       nonce_i,
    output logic [MSG_W-1:0]  msg_o
);
    assign msg_o = {hdr_i, nonce_i, 1'b1, 319'b0, MSG_LEN_FIELD};
endmodule

// File: rtl/nonce_scheduler.sv
// nonce_scheduler: walks a nonce range through the SHA-256d core and reports hashes below target.
module nonce_scheduler
    import sha_pkg::*;
#(
    parameter bit STOP_ON_FIND = 1'b1,
    parameter int TIMEOUT_CYC  = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [HDR_W-1:0]  job_header,
    input  logic [HASH_W-1:0] job_target,
    input  logic [31:0]       nonce_start,
    input  logic [31:0]       nonce_end,
    input  logic              abort,
    output logic              core_start,
    output logic [MSG_W-1:0]  core_message,
    input  logic              core_done,
    input  logic [HASH_W-1:0] core_hash,
    output logic              found_valid,
    input  logic              found_ready,
    output logic [31:0]       found_nonce,
    output logic [HASH_W-1:0] found_hash,
    output logic              busy,
    output logic              exhausted,
    output logic              timeout_err,
    output logic [31:0]       nonce_cur
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYC);

    state_t             state_q, state_d;
    logic [HDR_W-1:32]  hdr_q, hdr_d;
    logic [HASH_W-1:0]  tgt_q, tgt_d, hash_q, hash_d, fh_q, fh_d;
    logic [31:0]        end_q, end_d, nonce_q, nonce_d, fn_q, fn_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               tmo_q, tmo_d, hit_q, hit_d, abort_q, abort_d, fv_q, fv_d;
    logic               job_ready_q, busy_q, start_q, exh_q;
    logic               abort_now;
    logic [MSG_W-1:0]   msg;
    logic               unused_nonce_slot;

    assign unused_nonce_slot = ^job_header[31:0];
    assign abort_now = abort_q | abort;

    sha_msg_pad u_pad (.hdr_i(hdr_q), .nonce_i(nonce_q), .msg_o(msg));

    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        tgt_d   = tgt_q;
        end_d   = end_q;
        nonce_d = nonce_q;
        hash_d  = hash_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        hit_d   = hit_q;
        fv_d    = fv_q;
        fn_d    = fn_q;
        fh_d    = fh_q;
        abort_d = (state_q == S_IDLE) ? 1'b0 : abort_now;
        case (state_q)
            S_IDLE: if (job_valid) begin
                hdr_d   = job_header[HDR_W-1:32];
                tgt_d   = job_target;
                end_d   = nonce_end;
                nonce_d = nonce_start;
                tmo_d   = 1'b0;
                hit_d   = 1'b0;
                state_d = (nonce_start > nonce_end) ? S_DONE : S_ISSUE;
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: if (core_done) begin
                hash_d  = core_hash;
                state_d = S_CHECK;
            end else begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_d == TMO) begin
                    tmo_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_CHECK: if (abort_now) begin
                state_d = S_IDLE;
            end else if (hash_q < tgt_q) begin
                hit_d   = 1'b1;
                fv_d    = 1'b1;
                fn_d    = nonce_q;
                fh_d    = hash_q;
                state_d = S_REPORT;
            end else if (nonce_q == end_q) begin
                state_d = S_DONE;
            end else begin
                nonce_d = nonce_q + 32'd1;
                state_d = S_ISSUE;
            end
            S_REPORT: if (found_ready) begin
                fv_d = 1'b0;
                if (STOP_ON_FIND || nonce_q == end_q || abort_now) begin
                    state_d = S_IDLE;
                end else begin
                    nonce_d = nonce_q + 32'd1;
                    state_d = S_ISSUE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            hdr_q       <= '0;
            tgt_q       <= '0;
            end_q       <= '0;
            nonce_q     <= '0;
            hash_q      <= '0;
            cnt_q       <= '0;
            tmo_q       <= 1'b0;
            hit_q       <= 1'b0;
            abort_q     <= 1'b0;
            fv_q        <= 1'b0;
            fn_q        <= '0;
            fh_q        <= '0;
            job_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            start_q     <= 1'b0;
            exh_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            tgt_q       <= tgt_d;
            end_q       <= end_d;
            nonce_q     <= nonce_d;
            hash_q      <= hash_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            hit_q       <= hit_d;
            abort_q     <= abort_d;
            fv_q        <= fv_d;
            fn_q        <= fn_d;
            fh_q        <= fh_d;
            job_ready_q <= state_d == S_IDLE;
            busy_q      <= state_d != S_IDLE;
            start_q     <= state_d == S_ISSUE;
            exh_q       <= state_d == S_DONE && !hit_d;
        end
    end

    assign job_ready    = job_ready_q;
    assign busy         = busy_q;
    assign core_start   = start_q;
    assign core_message = busy_q ? msg : '0;
    assign found_valid  = fv_q;
    assign found_nonce  = fn_q;
    assign found_hash   = fh_q;
    assign exhausted    = exh_q;
    assign timeout_err  = tmo_q;
    assign nonce_cur    = nonce_q;
endmodule
